aes_block_sink: RTL and testbench

- Output-side counterpart to the plaintext/file_in source feeding AES_top.
- Accepts 128-bit result blocks (cipher_text / file_out) over a valid/ready handshake and buffers them in a block FIFO.
- Drains the FIFO as a byte stream, MSB byte first, for transfer to the output file/RAM port.
- Sits between AES_top and the byte-wide output writer.

---
 rtl/aes_block_sink_if.sv | 12 +
 rtl/aes_block_sink.sv | 63 ++++++
 tb/tb_aes_block_sink.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_sink_if.sv
// aes_block_sink_if: block-in / byte-out handshake bundle for aes_block_sink
interface aes_block_sink_if;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         blk_ready;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_ready;
    logic         byte_last;
    modport master (output blk_valid, blk_data, byte_ready, input blk_ready, byte_valid, byte_data, byte_last);
    modport slave  (input blk_valid, blk_data, byte_ready, output blk_ready, byte_valid, byte_data, byte_last);
endinterface

// File: rtl/aes_block_sink.sv
// aes_block_sink: buffers 128-bit AES result blocks and streams them out MSB byte first
module aes_block_sink #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    aes_block_sink_if.slave  bus,
    input  logic             clear,
    output logic [AW:0]      fifo_count,
    output logic [15:0]      blocks_out
);
    typedef enum logic {EMPTY, SEND} state_t;
    state_t         state;
    logic [127:0]   mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [127:0]   shift;
    logic [3:0]     idx;
    logic           push, pop, done;
    // ready is gated by reset so nothing is offered while the sink is held in reset
    assign bus.blk_ready  = rst && fifo_count != (AW+1)'(DEPTH) && !clear;
    assign push           = bus.blk_valid && bus.blk_ready;
    assign done           = state == SEND && bus.byte_ready && idx == 4'd15;
    assign pop            = fifo_count != '0 && (state == EMPTY || done);
    assign bus.byte_valid = state == SEND;
    assign bus.byte_data  = shift[127:120];
    assign bus.byte_last  = state == SEND && idx == 4'd15;
    always_ff @(posedge clk)
        if (push) mem[wp] <= bus.blk_data;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wp         <= '0;
            rp         <= '0;
            fifo_count <= '0;
            blocks_out <= '0;
            idx        <= '0;
            shift      <= '0;
            state      <= EMPTY;
        end else if (clear) begin
            wp         <= '0;
            rp         <= '0;
            fifo_count <= '0;
            blocks_out <= '0;
            idx        <= '0;
            shift      <= '0;
            state      <= EMPTY;
        end else begin
            if (push) wp <= wp + 1'b1;
            // the final byte's handshake reloads the serializer directly, so blocks run back to back
            if (pop) begin
                rp    <= rp + 1'b1;
                shift <= mem[rp];
                idx   <= '0;
            end else if (state == SEND && bus.byte_ready && !done) begin
                shift <= {shift[119:0], 8'h00};
                idx   <= idx + 1'b1;
            end
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            if (done) blocks_out <= blocks_out + 1'b1;
            if (pop) state <= SEND;
            else if (done) state <= EMPTY;
        end
endmodule

// File: tb/tb_aes_block_sink.sv
// tb_aes_block_sink: randomized scenario bench with a byte-queue reference model
module tb_aes_block_sink;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    logic          clk = 0;
    logic          rst = 0;
    logic          clear = 0;
    logic [AW:0]   fifo_count;
    logic [15:0]   blocks_out;
    aes_block_sink_if bus();
    aes_block_sink #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .clear(clear),
        .fifo_count(fifo_count), .blocks_out(blocks_out)
    );
    always #5 clk = ~clk;
    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int exp_blocks = 0;
    logic [7:0] obs_data[$];
    logic       obs_last[$];
    int         obs_cyc[$];
    logic [7:0] exp_q[$];
    always @(posedge clk) cyc <= cyc + 1;
    // record every byte that will be consumed at the coming edge
    always @(negedge clk)
        if (rst && !clear && bus.byte_valid && bus.byte_ready) begin
            obs_data.push_back(bus.byte_data);
            obs_last.push_back(bus.byte_last);
            obs_cyc.push_back(cyc);
        end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic add_block(input logic [127:0] b);
        for (int i = 0; i < 16; i++) exp_q.push_back(b[127-8*i -: 8]);
    endtask
    task automatic wait_bytes(input int n, output bit ok);
        for (int k = 0; k < 2000 && obs_data.size() < n; k++) tick();
        ok = obs_data.size() >= n;
    endtask
    task automatic fresh();
        obs_data.delete();
        obs_last.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask
    task automatic test_reset();
        bus.blk_valid = 0;
        bus.blk_data = '0;
        bus.byte_ready = 0;
        rst = 0;
        tick();
        tick();
        checks++;
        if (bus.byte_valid !== 1'b0 || bus.byte_last !== 1'b0 || bus.byte_data !== 8'h00 || bus.blk_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b last=%b data=%h ready=%b, want 0 0 00 0", bus.byte_valid, bus.byte_last, bus.byte_data, bus.blk_ready);
        end
        checks++;
        if (fifo_count !== '0 || blocks_out !== 16'h0) begin
            fails++;
            $display("FAIL reset_counts: fifo_count=%0d blocks_out=%0d, want 0 0", fifo_count, blocks_out);
        end
        rst = 1;
        tick();
        checks++;
        if (bus.blk_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b want 1", bus.blk_ready);
        end
    endtask
    task automatic test_single();
        bit ok;
        logic [127:0] b = 128'h100F0E0D0C0B0A090807060504030201;
        fresh();
        add_block(b);
        bus.byte_ready = 1;
        bus.blk_valid = 1;
        bus.blk_data = b;
        tick();
        bus.blk_valid = 0;
        checks++;
        if (fifo_count !== 5'd1 || bus.byte_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_accept: fifo_count=%0d byte_valid=%b, want 1 0", fifo_count, bus.byte_valid);
        end
        tick();
        checks++;
        if (bus.byte_valid !== 1'b1 || bus.byte_data !== 8'h10 || fifo_count !== 5'd0) begin
            fails++;
            $display("FAIL single_latency: valid=%b data=%h count=%0d, want 1 10 0", bus.byte_valid, bus.byte_data, fifo_count);
        end
        wait_bytes(16, ok);
        exp_blocks++;
        tick();
        checks++;
        if (!ok || obs_data.size() != 16) begin
            fails++;
            $display("FAIL single_count: got %0d bytes want 16", obs_data.size());
        end else
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i % 16 == 15) || obs_cyc[i] != obs_cyc[0] + i) begin
                    fails++;
                    $display("FAIL single_byte%0d: got %h last=%b cyc=%0d, want %h last=%b cyc=%0d", i, obs_data[i], obs_last[i], obs_cyc[i], exp_q[i], i % 16 == 15, obs_cyc[0] + i);
                end
            end
        checks++;
        if (blocks_out !== 16'(exp_blocks) || bus.byte_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_done: blocks_out=%0d valid=%b, want %0d 0", blocks_out, bus.byte_valid, exp_blocks);
        end
    endtask
    task automatic test_back_to_back();
        bit ok;
        logic [127:0] a = 128'h00FFFEFDFCFBFAF9F8F7F6F5F4F3F2F1;
        logic [127:0] b = 128'hF0EFEEEDECEBEAE9E8E7E6E5E4E3E2E1;
        fresh();
        add_block(a);
        add_block(b);
        bus.byte_ready = 1;
        bus.blk_valid = 1;
        bus.blk_data = a;
        tick();
        bus.blk_data = b;
        tick();
        bus.blk_valid = 0;
        wait_bytes(32, ok);
        exp_blocks += 2;
        tick();
        checks++;
        if (!ok || obs_data.size() != 32) begin
            fails++;
            $display("FAIL b2b_count: got %0d bytes want 32", obs_data.size());
        end else
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i % 16 == 15) || obs_cyc[i] != obs_cyc[0] + i) begin
                    fails++;
                    $display("FAIL b2b_byte%0d: got %h last=%b cyc=%0d, want %h last=%b cyc=%0d", i, obs_data[i], obs_last[i], obs_cyc[i], exp_q[i], i % 16 == 15, obs_cyc[0] + i);
                end
            end
        checks++;
        if (blocks_out !== 16'(exp_blocks)) begin
            fails++;
            $display("FAIL b2b_blocks_out: got %0d want %0d", blocks_out, exp_blocks);
        end
    endtask
    task automatic test_full();
        bit ok;
        logic [127:0] b;
        fresh();
        bus.byte_ready = 0;
        for (int i = 0; i < 20; i++) begin
            b = {$urandom, $urandom, $urandom, $urandom};
            bus.blk_valid = 1;
            bus.blk_data = b;
            checks++;
            if (bus.blk_ready !== (i < DEPTH + 1)) begin
                fails++;
                $display("FAIL full_ready_attempt%0d: got %b want %b", i, bus.blk_ready, i < DEPTH + 1);
            end
            if (i < DEPTH + 1) add_block(b);
            tick();
        end
        bus.blk_valid = 0;
        checks++;
        if (fifo_count !== 5'(DEPTH) || bus.blk_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_state: fifo_count=%0d ready=%b, want %0d 0", fifo_count, bus.blk_ready, DEPTH);
        end
        bus.byte_ready = 1;
        for (int k = 0; k < 600 && obs_data.size() < 16 * (DEPTH + 1); k++) begin
            checks++;
            if (bus.blk_ready !== (obs_data.size() >= 16)) begin
                fails++;
                $display("FAIL full_ready_release: got %b want %b after %0d bytes", bus.blk_ready, obs_data.size() >= 16, obs_data.size());
            end
            tick();
        end
        exp_blocks += DEPTH + 1;
        tick();
        checks++;
        if (obs_data.size() != exp_q.size()) begin
            fails++;
            $display("FAIL full_count: got %0d bytes want %0d", obs_data.size(), exp_q.size());
        end else
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i % 16 == 15)) begin
                    fails++;
                    $display("FAIL full_byte%0d: got %h last=%b, want %h last=%b", i, obs_data[i], obs_last[i], exp_q[i], i % 16 == 15);
                end
            end
        checks++;
        if (blocks_out !== 16'(exp_blocks)) begin
            fails++;
            $display("FAIL full_blocks_out: got %0d want %0d", blocks_out, exp_blocks);
        end
        ok = 1;
    endtask
    task automatic test_backpressure();
        logic [127:0] b = 128'h706F6E6D6C6B6A696867666564636261;
        logic [7:0] pd;
        logic pl, stalled;
        fresh();
        add_block(b);
        bus.byte_ready = 0;
        bus.blk_valid = 1;
        bus.blk_data = b;
        tick();
        bus.blk_valid = 0;
        for (int k = 0; k < 400 && obs_data.size() < 16; k++) begin
            bus.byte_ready = 1'($urandom_range(0, 1));
            pd = bus.byte_data;
            pl = bus.byte_last;
            stalled = bus.byte_valid && !bus.byte_ready;
            tick();
            if (stalled) begin
                checks++;
                if (bus.byte_data !== pd || bus.byte_last !== pl) begin
                    fails++;
                    $display("FAIL bp_stable: data=%h last=%b, want %h %b", bus.byte_data, bus.byte_last, pd, pl);
                end
            end
        end
        bus.byte_ready = 1;
        exp_blocks++;
        tick();
        tick();
        checks++;
        if (obs_data.size() != 16) begin
            fails++;
            $display("FAIL bp_count: got %0d bytes want 16", obs_data.size());
        end else
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i == 15)) begin
                    fails++;
                    $display("FAIL bp_byte%0d: got %h last=%b, want %h last=%b", i, obs_data[i], obs_last[i], exp_q[i], i == 15);
                end
            end
        checks++;
        if (blocks_out !== 16'(exp_blocks)) begin
            fails++;
            $display("FAIL bp_blocks_out: got %0d want %0d", blocks_out, exp_blocks);
        end
    endtask
    task automatic test_clear();
        bit ok;
        logic [127:0] b = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] n = 128'h504F4E4D4C4B4A494847464544434241;
        fresh();
        add_block(b);
        bus.byte_ready = 1;
        bus.blk_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bus.blk_data = i == 0 ? b : {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        bus.blk_valid = 0;
        wait_bytes(5, ok);
        clear = 1;
        bus.blk_valid = 1;
        bus.blk_data = {$urandom, $urandom, $urandom, $urandom};
        #1;
        checks++;
        if (bus.blk_ready !== 1'b0) begin
            fails++;
            $display("FAIL clear_ready: got %b want 0", bus.blk_ready);
        end
        tick();
        clear = 0;
        bus.blk_valid = 0;
        exp_blocks = 0;
        checks++;
        if (bus.byte_valid !== 1'b0 || fifo_count !== '0 || blocks_out !== 16'h0) begin
            fails++;
            $display("FAIL clear_state: valid=%b count=%0d blocks_out=%0d, want 0 0 0", bus.byte_valid, fifo_count, blocks_out);
        end
        tick();
        tick();
        checks++;
        if (!ok || obs_data.size() != 5 || fifo_count !== '0) begin
            fails++;
            $display("FAIL clear_drop: bytes=%0d count=%0d, want 5 0", obs_data.size(), fifo_count);
        end else
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs_data[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL clear_prefix%0d: got %h want %h", i, obs_data[i], exp_q[i]);
                end
            end
        fresh();
        add_block(n);
        bus.blk_valid = 1;
        bus.blk_data = n;
        tick();
        bus.blk_valid = 0;
        wait_bytes(16, ok);
        exp_blocks++;
        tick();
        checks++;
        if (!ok || obs_data.size() != 16) begin
            fails++;
            $display("FAIL clear_resume_count: got %0d bytes want 16", obs_data.size());
        end else
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i == 15)) begin
                    fails++;
                    $display("FAIL clear_resume_byte%0d: got %h last=%b, want %h last=%b", i, obs_data[i], obs_last[i], exp_q[i], i == 15);
                end
            end
        checks++;
        if (blocks_out !== 16'(exp_blocks)) begin
            fails++;
            $display("FAIL clear_blocks_out: got %0d want %0d", blocks_out, exp_blocks);
        end
    endtask
    task automatic test_async_reset();
        bit ok;
        logic [127:0] b = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] n = 128'h302F2E2D2C2B2A292827262524232221;
        fresh();
        bus.byte_ready = 1;
        bus.blk_valid = 1;
        bus.blk_data = b;
        tick();
        bus.blk_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        bus.blk_valid = 0;
        wait_bytes(8, ok);
        #2;
        rst = 0;
        #1;
        checks++;
        if (bus.byte_valid !== 1'b0 || bus.byte_data !== 8'h00 || bus.byte_last !== 1'b0 || bus.blk_ready !== 1'b0) begin
            fails++;
            $display("FAIL areset_outputs: valid=%b data=%h last=%b ready=%b, want 0 00 0 0", bus.byte_valid, bus.byte_data, bus.byte_last, bus.blk_ready);
        end
        checks++;
        if (fifo_count !== '0 || blocks_out !== 16'h0) begin
            fails++;
            $display("FAIL areset_counts: count=%0d blocks_out=%0d, want 0 0", fifo_count, blocks_out);
        end
        tick();
        tick();
        rst = 1;
        exp_blocks = 0;
        tick();
        tick();
        checks++;
        if (!ok || obs_data.size() != 8 || bus.byte_valid !== 1'b0 || fifo_count !== '0) begin
            fails++;
            $display("FAIL areset_discard: bytes=%0d valid=%b count=%0d, want 8 0 0", obs_data.size(), bus.byte_valid, fifo_count);
        end
        fresh();
        add_block(n);
        bus.blk_valid = 1;
        bus.blk_data = n;
        tick();
        bus.blk_valid = 0;
        wait_bytes(16, ok);
        exp_blocks++;
        tick();
        checks++;
        if (!ok || obs_data.size() != 16) begin
            fails++;
            $display("FAIL areset_resume_count: got %0d bytes want 16", obs_data.size());
        end else
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i == 15)) begin
                    fails++;
                    $display("FAIL areset_resume_byte%0d: got %h last=%b, want %h last=%b", i, obs_data[i], obs_last[i], exp_q[i], i == 15);
                end
            end
        checks++;
        if (blocks_out !== 16'(exp_blocks)) begin
            fails++;
            $display("FAIL areset_blocks_out: got %0d want %0d", blocks_out, exp_blocks);
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
